// File: rtl/stdp_net_pkg.sv
// Shared constants and saturating arithmetic for the STDP spiking core.
package stdp_net_pkg;

    localparam int N_PRE_DEF       = 5;
    localparam int V_W_DEF         = 10;
    localparam int W_W_DEF         = 8;
    localparam int T_W_DEF         = 4;
    localparam int PRE_TH_BASE_DEF = 100;
    localparam int PRE_TH_STEP_DEF = 40;
    localparam int POST_TH_DEF     = 200;
    localparam int LEAK_SHIFT_DEF  = 2;
    localparam int WINDOW_DEF      = 8;
    localparam int W_INIT_DEF      = 16;
    localparam int W_MIN_DEF       = 0;
    localparam int W_MAX_DEF       = 255;

    // a + b, clamped to max_v (operands are small, so 32 bits never wrap)
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_v);
        return (a + b > max_v) ? max_v : a + b;
    endfunction

    // a - b, clamped to min_v without going through a negative value
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned min_v);
        return (a < b + min_v) ? min_v : a - b;
    endfunction

endpackage

// File: rtl/lif_neuron_p.sv
// Leaky integrate-and-fire neuron: spike from the membrane register, reset on spike.
module lif_neuron_p
    import stdp_net_pkg::*;
#(
    parameter int V_W        = 10,
    parameter int TH         = 100,
    parameter int LEAK_SHIFT = 2,
    parameter int I_W        = 8
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [I_W-1:0] i_in,
    output logic           spike,
    output logic [V_W-1:0] v
);

    localparam int unsigned V_MAX = (1 << V_W) - 1;

    logic [V_W-1:0] v_q, v_d;

    assign spike = en && (int'(v_q) >= TH);
    assign v     = v_q;

    // Leak then integrate with saturation; a disabled or firing neuron goes to 0.
    always_comb begin
        v_d = '0;
        if (en && !spike)
            v_d = V_W'(sat_add(32'(v_q) - 32'(v_q >> LEAK_SHIFT), 32'(i_in), V_MAX));
    end

    // Membrane register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= v_d;
    end

endmodule

// File: rtl/stdp_net_core.sv
// N_PRE LIF inputs feeding one LIF output through STDP-learned weights,
// with a host weight read/write port.
module stdp_net_core
    import stdp_net_pkg::*;
#(
    parameter int N_PRE       = N_PRE_DEF,
    parameter int V_W         = V_W_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int T_W         = T_W_DEF,
    parameter int PRE_TH_BASE = PRE_TH_BASE_DEF,
    parameter int PRE_TH_STEP = PRE_TH_STEP_DEF,
    parameter int POST_TH     = POST_TH_DEF,
    parameter int LEAK_SHIFT  = LEAK_SHIFT_DEF,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int W_INIT      = W_INIT_DEF,
    parameter int W_MIN       = W_MIN_DEF,
    parameter int W_MAX       = W_MAX_DEF,
    localparam int SEL_W      = (N_PRE > 1) ? $clog2(N_PRE) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       current,
    input  logic [N_PRE-1:0] pre_en,
    input  logic             learn_en,
    input  logic [SEL_W-1:0] w_sel,
    input  logic             w_wr_en,
    input  logic [W_W-1:0]   w_wr_data,
    output logic [W_W-1:0]   w_rd,
    output logic [N_PRE-1:0] pre_spike,
    output logic             post_spike,
    output logic [V_W-1:0]   v_post,
    output logic             upd_flag
);

    localparam int AGE_MAX = (1 << T_W) - 1;
    localparam int V_MAX   = (1 << V_W) - 1;

    logic [N_PRE-1:0][V_W-1:0] v_pre;
    logic [N_PRE-1:0][W_W-1:0] weight, weight_d;
    logic [N_PRE-1:0][T_W-1:0] age, age_e;
    logic [N_PRE-1:0]          valid, changed;
    logic [T_W-1:0]            post_age, post_e;
    logic                      post_valid;
    logic [V_W-1:0]            post_i;

    // Presynaptic membranes stay internal; fold them so they are consumed.
    logic unused_v_pre;
    assign unused_v_pre = ^v_pre;

    for (genvar g = 0; g < N_PRE; g++) begin : g_pre
        lif_neuron_p #(
            .V_W(V_W), .TH(PRE_TH_BASE + g * PRE_TH_STEP),
            .LEAK_SHIFT(LEAK_SHIFT), .I_W(8)
        ) u_lif (
            .clk(clk), .rst_n(rst_n), .en(pre_en[g]), .i_in(current),
            .spike(pre_spike[g]), .v(v_pre[g])
        );
    end

    lif_neuron_p #(
        .V_W(V_W), .TH(POST_TH), .LEAK_SHIFT(LEAK_SHIFT), .I_W(V_W)
    ) u_post (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .i_in(post_i),
        .spike(post_spike), .v(v_post)
    );

    assign w_rd = (int'(w_sel) < N_PRE) ? weight[w_sel] : '0;

    // Postsynaptic drive: saturating sum of weights on channels spiking now.
    always_comb begin
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < N_PRE; i++)
            if (pre_spike[i]) acc = sat_add(acc, 32'(weight[i]), V_MAX);
        post_i = V_W'(acc);
    end

    // Effective spike ages: 0 on a spike, otherwise count up and stick at max.
    always_comb begin
        age_e  = '0;
        post_e = '0;
        for (int i = 0; i < N_PRE; i++) begin
            if (pre_spike[i])                  age_e[i] = '0;
            else if (int'(age[i]) == AGE_MAX)  age_e[i] = age[i];
            else                               age_e[i] = age[i] + T_W'(1);
        end
        if (post_spike)                   post_e = '0;
        else if (int'(post_age) == AGE_MAX) post_e = post_age;
        else                              post_e = post_age + T_W'(1);
    end

    // STDP: post spike potentiates recent pre activity (a coincident pre spike
    // counts as causal with age 0); a lone pre spike depresses after a recent
    // post spike. A host write to the same channel wins.
    always_comb begin
        int unsigned w_new;
        weight_d = weight;
        changed  = '0;
        w_new    = 0;
        for (int i = 0; i < N_PRE; i++) begin
            w_new = 32'(weight[i]);
            if (learn_en) begin
                if (post_spike) begin
                    if ((valid[i] || pre_spike[i]) && int'(age_e[i]) < WINDOW)
                        w_new = sat_add(w_new, WINDOW - int'(age_e[i]), W_MAX);
                end else if (pre_spike[i] && post_valid && int'(post_e) < WINDOW) begin
                    w_new = sat_sub(w_new, WINDOW - int'(post_e), W_MIN);
                end
            end
            if (w_wr_en && int'(w_sel) == i) begin
                weight_d[i] = w_wr_data;
            end else begin
                weight_d[i] = W_W'(w_new);
                changed[i]  = (W_W'(w_new) != weight[i]);
            end
        end
    end

    // Learning state: weights, ages, first-spike flags and the update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PRE; i++) begin
                weight[i] <= W_W'(W_INIT);
                age[i]    <= T_W'(AGE_MAX);
            end
            valid      <= '0;
            post_age   <= T_W'(AGE_MAX);
            post_valid <= 1'b0;
            upd_flag   <= 1'b0;
        end else begin
            weight     <= weight_d;
            age        <= age_e;
            valid      <= valid | pre_spike;
            post_age   <= post_e;
            post_valid <= post_valid | post_spike;
            upd_flag   <= |changed;
        end
    end

endmodule

// File: tb/tb_stdp_net_core.sv
// Directed bench for stdp_net_core with hand-computed expectations.
module tb_stdp_net_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] current = '0;
    logic [4:0] pre_en = '0;
    logic       learn_en = 1'b0;
    logic [2:0] w_sel = '0;
    logic       w_wr_en = 1'b0;
    logic [7:0] w_wr_data = '0;
    logic [7:0] w_rd;
    logic [4:0] pre_spike;
    logic       post_spike;
    logic [9:0] v_post;
    logic       upd_flag;

    int n_chk = 0;
    int n_fail = 0;

    stdp_net_core dut (
        .clk(clk), .rst_n(rst_n), .current(current), .pre_en(pre_en),
        .learn_en(learn_en), .w_sel(w_sel), .w_wr_en(w_wr_en),
        .w_wr_data(w_wr_data), .w_rd(w_rd), .pre_spike(pre_spike),
        .post_spike(post_spike), .v_post(v_post), .upd_flag(upd_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        current = '0; pre_en = '0; learn_en = 1'b0; w_wr_en = 1'b0; w_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr(input int sel, input int data);
        w_sel = 3'(sel); w_wr_data = 8'(data); w_wr_en = 1'b1;
        tick();
        w_wr_en = 1'b0;
    endtask

    // Single-channel STDP stimulus on channel 0; caller is at the cycle before t1.
    task automatic start_pair();
        w_sel = 3'd0; pre_en = 5'b00001; current = 8'd100; learn_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_pre_spike", pre_spike, 0);
        chk("rst_post_spike", post_spike, 0);
        chk("rst_v_post", v_post, 0);
        chk("rst_upd", upd_flag, 0);
        for (int i = 0; i < 5; i++) begin
            w_sel = 3'(i); #1;
            chk($sformatf("rst_w%0d", i), w_rd, 16);
        end

        // host write to channel 2
        wr(2, 200);
        chk("wr_w2", w_rd, 200);
        for (int i = 0; i < 5; i++) begin
            if (i != 2) begin
                w_sel = 3'(i); #1;
                chk($sformatf("wr_other_w%0d", i), w_rd, 16);
            end
        end

        // presynaptic oscillation, learning off
        do_reset();
        pre_en = 5'b00001; current = 8'd100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("osc_c%0d", k), pre_spike, (k % 2 == 1) ? 1 : 0);
        end
        chk("osc_w0_kept", w_rd, 16);

        // STDP pair from w0=220
        do_reset();
        wr(0, 220);
        start_pair();
        tick();
        chk("pair_t1_pre", pre_spike, 1);
        chk("pair_t1_post", post_spike, 0);
        tick();
        chk("pair_t2_post", post_spike, 1);
        chk("pair_t2_vpost", v_post, 220);
        chk("pair_t2_pre", pre_spike, 0);
        chk("pair_t2_w0", w_rd, 220);
        chk("pair_t2_upd", upd_flag, 0);
        tick();
        chk("pair_t3_w0", w_rd, 227);
        chk("pair_t3_upd", upd_flag, 1);
        chk("pair_t3_pre", pre_spike, 1);
        chk("pair_t3_post", post_spike, 0);
        tick();
        chk("pair_t4_w0", w_rd, 220);
        chk("pair_t4_upd", upd_flag, 1);
        chk("pair_t4_vpost", v_post, 227);
        tick();
        chk("pair_t5_w0", w_rd, 227);

        // asynchronous reset mid-run clears learned state at once
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v_post", v_post, 0);
        chk("mid_rst_post", post_spike, 0);
        chk("mid_rst_pre", pre_spike, 0);
        chk("mid_rst_upd", upd_flag, 0);
        for (int i = 0; i < 5; i++) begin
            w_sel = 3'(i); #1;
            chk($sformatf("mid_rst_w%0d", i), w_rd, 16);
        end
        do_reset();

        // host write overrides a same-cycle LTP, then LTD acts on the written value
        wr(0, 220);
        start_pair();
        tick();
        tick();
        w_wr_en = 1'b1; w_wr_data = 8'd50;
        tick();
        w_wr_en = 1'b0;
        chk("ovr_t3_w0", w_rd, 50);
        tick();
        chk("ovr_t4_w0", w_rd, 43);

        // LTP clamps at W_MAX with a real change
        do_reset();
        wr(0, 253);
        start_pair();
        tick(); tick(); tick();
        chk("clampH_t3_w0", w_rd, 255);
        chk("clampH_t3_upd", upd_flag, 1);
        tick();
        chk("clampH_t4_w0", w_rd, 248);

        // LTP at W_MAX leaves the value unchanged: no update flag
        do_reset();
        wr(0, 255);
        start_pair();
        tick();
        tick();
        chk("nochg_t2_vpost", v_post, 255);
        tick();
        chk("nochg_t3_w0", w_rd, 255);
        chk("nochg_t3_upd", upd_flag, 0);
        tick();
        chk("nochg_t4_w0", w_rd, 248);
        chk("nochg_t4_upd", upd_flag, 1);

        // LTD clamps at W_MIN; post driven by channel 1
        do_reset();
        wr(0, 3);
        wr(1, 200);
        w_sel = 3'd0; pre_en = 5'b00010; current = 8'd100; learn_en = 1'b0;
        tick();
        chk("ltd_c1_pre", pre_spike, 0);
        tick();
        chk("ltd_c2_pre", pre_spike, 2);
        tick();
        chk("ltd_c3_post", post_spike, 1);
        chk("ltd_c3_vpost", v_post, 200);
        pre_en = 5'b00011;
        tick();
        chk("ltd_c4_pre", pre_spike, 1);
        chk("ltd_c4_post", post_spike, 0);
        learn_en = 1'b1;
        tick();
        learn_en = 1'b0;
        chk("ltd_c5_w0", w_rd, 0);
        chk("ltd_c5_upd", upd_flag, 1);
        w_sel = 3'd1; #1;
        chk("ltd_c5_w1", w_rd, 200);

        // postsynaptic input saturation with all five channels at 255
        do_reset();
        for (int i = 0; i < 5; i++) wr(i, 255);
        w_sel = 3'd4; current = 8'd255; pre_en = 5'b10000; learn_en = 1'b0;
        tick();
        chk("sat_c1_pre", pre_spike, 0);
        pre_en = 5'b11111;
        tick();
        chk("sat_c2_pre", pre_spike, 31);
        chk("sat_c2_vpost", v_post, 0);
        tick();
        chk("sat_c3_vpost", v_post, 1023);
        chk("sat_c3_post", post_spike, 1);
        chk("sat_w4", w_rd, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
